// File: rtl/tacc_pulse_delay.sv
// tacc_pulse_delay: trigger-edge delayed pulse generator.
// A trigger edge starts a programmable delay, then a programmable-width pulse.
// Output polarity, retrigger behaviour and overrun reporting are configurable.
module tacc_pulse_delay #(
    parameter int unsigned CNT_W      = 8,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             enable_i,
    input  logic             trig_i,
    input  logic [CNT_W-1:0] delay_i,
    input  logic [CNT_W-1:0] width_i,
    input  logic             mode_i,
    input  logic             clear_i,
    output logic             pulse_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             overrun_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DELAY,
        S_PULSE
    } state_t;

    localparam logic INACT = ACTIVE_LOW ? 1'b1 : 1'b0;
    localparam logic ACT   = ~INACT;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] w_lat_q;
    logic             trig_prev_q;
    logic             pulse_q;
    logic             busy_q;
    logic             done_q;
    logic             overrun_q;

    logic             trig_evt;
    logic [CNT_W-1:0] width_d;

    // Trigger edge in polarity-independent terms; a zero width behaves as one.
    always_comb begin
        trig_evt = (trig_i == ACT) && (trig_prev_q == INACT);
        width_d  = (width_i == '0) ? {{(CNT_W-1){1'b0}}, 1'b1} : width_i;
    end

    // Sequencer: edge history, delay/pulse counting and all registered outputs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            w_lat_q     <= '0;
            trig_prev_q <= INACT;
            pulse_q     <= INACT;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            // Edge history runs even while disabled, so a held level never fires.
            trig_prev_q <= trig_i;
            done_q      <= 1'b0;
            if (clear_i) begin
                overrun_q <= 1'b0;
            end
            if (!enable_i) begin
                state_q <= S_IDLE;
                cnt_q   <= '0;
                pulse_q <= INACT;
                busy_q  <= 1'b0;
            end else if (trig_evt && (state_q == S_IDLE || mode_i)) begin
                // Fresh start or retrigger: timing restarts from this edge.
                w_lat_q <= width_d;
                cnt_q   <= delay_i;
                state_q <= S_DELAY;
                pulse_q <= INACT;
                busy_q  <= 1'b1;
            end else begin
                // Ignored trigger while busy sets overrun, overriding a same-cycle clear.
                if (trig_evt) begin
                    overrun_q <= 1'b1;
                end
                case (state_q)
                    S_DELAY: begin
                        if (cnt_q == '0) begin
                            state_q <= S_PULSE;
                            pulse_q <= ACT;
                            cnt_q   <= w_lat_q - 1'b1;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                    S_PULSE: begin
                        if (cnt_q == '0) begin
                            state_q <= S_IDLE;
                            pulse_q <= INACT;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign pulse_o   = pulse_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign overrun_o = overrun_q;

endmodule

// File: tb/tb_tacc_pulse_delay.sv
// Directed bench for tacc_pulse_delay (ACTIVE_LOW=1, CNT_W=8).
// Each table row is driven before one rising edge; outputs are compared after it.
module tb_tacc_pulse_delay;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       trig;
    logic [7:0] delay;
    logic [7:0] width;
    logic       mode;
    logic       clear;
    logic       pulse;
    logic       busy;
    logic       done;
    logic       overrun;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       t;
        logic       en;
        logic       m;
        logic       c;
        logic [7:0] d;
        logic [7:0] w;
        logic       ep;
        logic       eb;
        logic       ed;
        logic       eo;
    } vec_t;

    vec_t vq[$];

    tacc_pulse_delay #(.CNT_W(8), .ACTIVE_LOW(1'b1)) dut (
        .clk_i    (clk),
        .rst_n_i  (rst_n),
        .enable_i (enable),
        .trig_i   (trig),
        .delay_i  (delay),
        .width_i  (width),
        .mode_i   (mode),
        .clear_i  (clear),
        .pulse_o  (pulse),
        .busy_o   (busy),
        .done_o   (done),
        .overrun_o(overrun)
    );

    always #5 clk = ~clk;

    task automatic add(input logic t, input logic en, input logic m, input logic c,
                       input logic [7:0] d, input logic [7:0] w,
                       input logic ep, input logic eb, input logic ed, input logic eo);
        vec_t v;
        v.t = t; v.en = en; v.m = m; v.c = c; v.d = d; v.w = w;
        v.ep = ep; v.eb = eb; v.ed = ed; v.eo = eo;
        vq.push_back(v);
    endtask

    task automatic check(input string name, input logic ep, input logic eb,
                         input logic ed, input logic eo);
        checks++;
        if ({pulse, busy, done, overrun} !== {ep, eb, ed, eo}) begin
            failures++;
            $display("FAIL %s: got pulse=%b busy=%b done=%b ovr=%b, want pulse=%b busy=%b done=%b ovr=%b",
                     name, pulse, busy, done, overrun, ep, eb, ed, eo);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        enable = 1'b1;
        trig   = 1'b1;
        delay  = 8'd0;
        width  = 8'd0;
        mode   = 1'b0;
        clear  = 1'b0;

        // Basic D=4 W=7, mode 0; delay/width changes mid-sequence have no effect.
        add(0,1,0,0,4,7, 1,1,0,0);
        for (int j = 1; j <= 4; j++)  add(1,1,0,0,9,2, 1,1,0,0);
        for (int j = 5; j <= 11; j++) add(1,1,0,0,9,2, 0,1,0,0);
        add(1,1,0,0,9,2, 1,0,1,0);
        add(1,1,0,0,9,2, 1,0,0,0);
        // D=0 W=0: one-cycle pulse at k+1, done at k+2.
        add(0,1,0,0,0,0, 1,1,0,0);
        add(1,1,0,0,0,0, 0,1,0,0);
        add(1,1,0,0,0,0, 1,0,1,0);
        add(1,1,0,0,0,0, 1,0,0,0);
        // Mode 0 second trigger at k+3: timing unchanged, overrun sticky until clear.
        add(0,1,0,0,4,7, 1,1,0,0);
        add(1,1,0,0,4,7, 1,1,0,0);
        add(1,1,0,0,4,7, 1,1,0,0);
        add(0,1,0,0,1,1, 1,1,0,1);
        add(1,1,0,0,1,1, 1,1,0,1);
        for (int j = 5; j <= 11; j++) add(1,1,0,0,1,1, 0,1,0,1);
        add(1,1,0,0,4,7, 1,0,1,1);
        add(1,1,0,1,4,7, 1,0,0,0);
        add(1,1,0,0,4,7, 1,0,0,0);
        // Ignored trigger coinciding with clear: set wins.
        add(0,1,0,0,4,7, 1,1,0,0);
        add(1,1,0,0,4,7, 1,1,0,0);
        add(0,1,0,1,4,7, 1,1,0,1);
        add(1,0,0,0,4,7, 1,0,0,1);
        add(1,1,0,0,4,7, 1,0,0,1);
        add(1,1,0,1,4,7, 1,0,0,0);
        // Mode 1 retrigger at k+7 while in PULSE.
        add(0,1,1,0,4,7, 1,1,0,0);
        for (int j = 1; j <= 4; j++)   add(1,1,1,0,4,7, 1,1,0,0);
        for (int j = 5; j <= 6; j++)   add(1,1,1,0,4,7, 0,1,0,0);
        add(0,1,1,0,4,7, 1,1,0,0);
        for (int j = 8; j <= 11; j++)  add(1,1,1,0,4,7, 1,1,0,0);
        for (int j = 12; j <= 18; j++) add(1,1,1,0,4,7, 0,1,0,0);
        add(1,1,1,0,4,7, 1,0,1,0);
        add(1,1,1,0,4,7, 1,0,0,0);
        // Enable dropped at k+6; held active level across enable rise does not fire.
        add(0,1,0,0,4,7, 1,1,0,0);
        for (int j = 1; j <= 4; j++)   add(1,1,0,0,4,7, 1,1,0,0);
        add(1,1,0,0,4,7, 0,1,0,0);
        add(1,0,0,0,4,7, 1,0,0,0);
        add(0,0,0,0,4,7, 1,0,0,0);
        add(0,1,0,0,4,7, 1,0,0,0);
        add(0,1,0,0,4,7, 1,0,0,0);
        add(1,1,0,0,4,7, 1,0,0,0);
        add(0,1,0,0,4,7, 1,1,0,0);
        for (int j = 12; j <= 15; j++) add(1,1,0,0,4,7, 1,1,0,0);
        for (int j = 16; j <= 22; j++) add(1,1,0,0,4,7, 0,1,0,0);
        add(1,1,0,0,4,7, 1,0,1,0);
        // Trigger on the PULSE terminal edge, mode 0: completes, overrun set.
        add(0,1,0,0,0,1, 1,1,0,0);
        add(1,1,0,0,0,1, 0,1,0,0);
        add(0,1,0,0,0,1, 1,0,1,1);
        add(1,1,0,1,0,1, 1,0,0,0);
        // Trigger on the PULSE terminal edge, mode 1: trigger wins, no done.
        add(0,1,1,0,0,1, 1,1,0,0);
        add(1,1,1,0,0,1, 0,1,0,0);
        add(0,1,1,0,0,1, 1,1,0,0);
        add(1,1,1,0,0,1, 0,1,0,0);
        add(1,1,1,0,0,1, 1,0,1,0);
        add(1,1,1,0,0,1, 1,0,0,0);

        #12;
        check("reset_state", 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vq[i]) begin
            @(negedge clk);
            trig   = vq[i].t;
            enable = vq[i].en;
            mode   = vq[i].m;
            clear  = vq[i].c;
            delay  = vq[i].d;
            width  = vq[i].w;
            @(posedge clk);
            #1;
            check($sformatf("row%0d", i), vq[i].ep, vq[i].eb, vq[i].ed, vq[i].eo);
        end

        // Asynchronous reset in the middle of PULSE.
        @(negedge clk);
        trig = 1'b0; enable = 1'b1; mode = 1'b0; clear = 1'b0; delay = 8'd4; width = 8'd7;
        @(negedge clk);
        trig = 1'b1;
        repeat (5) @(negedge clk);
        check("pre_reset_pulse", 1'b0, 1'b1, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int j = 0; j < 10; j++) begin
            @(posedge clk);
            #1;
            check($sformatf("post_reset%0d", j), 1'b1, 1'b0, 1'b0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tacc_pulse_delay.md
Name: tacc_pulse_delay

Overview:
- Parametrised successor to the fixed-timing tACC retard block.
- On a trigger edge it waits a programmable delay, then drives a programmable-width output pulse. Output polarity is configurable, and a mode selects whether triggers that arrive while busy are ignored or restart the sequence.
- It sits between the RTC bus control FSM and the RTC chip-select/output-enable pins, so bus access timing meets tACC.

Parameters:
- CNT_W, 8, width of delay/width counters and of delay_i/width_i.
- ACTIVE_LOW, 1, 1: trig_i and pulse_o active-low; 0: both active-high.

Ports:
- clk_i  in  1  system clock; all state changes on its rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- enable_i  in  1  block enable; low aborts any sequence.
- trig_i  in  1  trigger input (synchronous to clk_i), polarity per ACTIVE_LOW.
- delay_i  in  CNT_W  delay D in clk cycles; sampled at trigger.
- width_i  in  CNT_W  pulse width W in clk cycles; sampled at trigger; 0 treated as 1.
- mode_i  in  1  0: ignore triggers while busy; 1: retrigger restarts.
- clear_i  in  1  synchronous clear of overrun_o.
- pulse_o  out  1  delayed pulse, polarity per ACTIVE_LOW.
- busy_o  out  1  high in DELAY or PULSE.
- done_o  out  1  1-cycle strobe when a pulse completes normally.
- overrun_o  out  1  sticky: a trigger was ignored (mode 0).

Behaviour:
- Reset (rst_n_i=0, asynchronous):
  - state=IDLE, cnt=0, d_lat=0, w_lat=0.
  - pulse_o=inactive (1 if ACTIVE_LOW else 0); busy_o=0, done_o=0, overrun_o=0.
  - trig_prev=inactive level.
  - Reset mid-sequence terminates it immediately with no done_o.
- Trigger event: trig_i at active level and trig_prev at inactive level, sampled at the same edge.
  - trig_prev updates every clock regardless of enable_i.
  - A level already held when enable_i rises therefore does not fire.
- All outputs are registered. done_o defaults to 0 each cycle.
- States: IDLE, DELAY, PULSE.
- IDLE:
  - On trigger at edge k: latch d_lat=delay_i, w_lat=max(width_i,1); cnt=delay_i; go to DELAY; busy_o=1 from edge k.
- DELAY:
  - If cnt==0: go to PULSE, pulse_o active, cnt=w_lat-1.
  - Otherwise cnt=cnt-1.
  - Net effect: pulse_o goes active at edge k+D+1. D=0 gives assertion at k+1.
- PULSE:
  - If cnt==0: go to IDLE, pulse_o inactive, busy_o=0, done_o=1 for one cycle.
  - Otherwise cnt=cnt-1.
  - Net effect: pulse_o is active for exactly W cycles (edges k+D+1 .. k+D+W).
- Trigger while busy, mode_i=0: ignored, sequence unaffected, overrun_o set to 1.
- Trigger while busy, mode_i=1: re-latch delay_i/width_i, cnt=delay_i, go to DELAY.
  - pulse_o goes inactive at that edge if it was in PULSE; no done_o.
  - Timing restarts from this edge.
- Simultaneous trigger and PULSE terminal edge (cnt==0):
  - mode 0: trigger ignored, overrun_o set, normal completion with done_o.
  - mode 1: trigger wins; go to DELAY, no done_o.
- overrun_o: clear_i=1 clears it. If clear_i and an ignored trigger coincide, set wins.
- enable_i=0 (synchronous, highest priority after reset):
  - Go to IDLE, pulse_o inactive, busy_o=0, no done_o. Triggers are ignored and do not set overrun_o.
- Counters: unsigned CNT_W. D max = 2^CNT_W-1, W max = 2^CNT_W-1; no wrap is possible.
- delay_i/width_i changes during a sequence have no effect except at a (re)trigger.

Test Plan:
- Reset defaults, ACTIVE_LOW=1: pulse_o=1, busy_o=0, done_o=0, overrun_o=0. Mid-PULSE rst_n_i low -> pulse_o=1 asynchronously; no done_o.
- D=4, W=7, trig falling edge detected at edge k -> pulse_o=0 at edges k+5..k+11, 1 at k+12; done_o=1 at k+12 only; busy_o=1 from k to k+11.
- D=0, W=0 -> pulse_o active for exactly 1 cycle at k+1; done_o at k+2.
- mode_i=0, D=4, W=7, second trigger at k+3 -> timing unchanged (pulse k+5..k+11); overrun_o=1 until clear_i pulse.
- mode_i=1, D=4, W=7, second trigger at k+7 (in PULSE) -> pulse_o inactive at k+7, active again k+12..k+18; one done_o at k+19.
- enable_i dropped at k+6 -> pulse_o inactive, busy_o=0 at k+6, no done_o. trig_i held active while enable_i rises -> no sequence starts until a fresh edge.
